// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: emits successive terms on f_out, either one per
// f_en rising edge or periodically from a prescaler, stopping before overflow.
module fib_seq_gen #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned IDX_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_en,
   input  logic             mode,
   input  logic             clr,
   output logic             f_valid,
   output logic [WIDTH-1:0] f_out,
   output logic [IDX_W-1:0] f_index,
   output logic             f_done
);

   localparam int unsigned      PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_f_en_q;
   logic [PW-1:0]    r_pre;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_a_bad, r_b_bad;

   logic             w_rise, w_tick, w_produce, w_emit;
   logic [WIDTH:0]   w_sum;

   assign w_rise    = f_en & ~r_f_en_q;
   assign w_tick    = mode & f_en & (r_pre == PRE_LAST);
   assign w_produce = (mode ? w_tick : w_rise) & ~clr & (r_state != S_DONE);
   // A produce event on an unrepresentable term only retires the sequence.
   assign w_emit    = w_produce & ~r_a_bad;
   assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
   assign f_done    = (r_state == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      if (clr)
         w_state_nxt = S_IDLE;
      else if (w_produce)
         w_state_nxt = r_a_bad ? S_DONE : S_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f_en_q <= 1'b0;
         r_pre    <= '0;
      end else begin
         r_f_en_q <= f_en;
         if (!f_en || !mode || clr || r_state == S_DONE || r_pre == PRE_LAST)
            r_pre <= '0;
         else
            r_pre <= r_pre + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_valid <= 1'b0;
         f_out   <= '0;
         f_index <= '0;
         r_a     <= '0;
         r_b     <= WIDTH'(1);
         r_a_bad <= 1'b0;
         r_b_bad <= 1'b0;
      end else begin
         f_valid <= w_emit;
         if (clr) begin
            f_out   <= '0;
            f_index <= '0;
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_a_bad <= 1'b0;
            r_b_bad <= 1'b0;
         end else if (w_emit) begin
            f_out   <= r_a;
            f_index <= f_index + IDX_W'(1);
            r_a     <= r_b;
            r_a_bad <= r_b_bad;
            r_b     <= w_sum[WIDTH-1:0];
            r_b_bad <= r_b_bad | w_sum[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: a reference Fibonacci model queues each
// expected term at stimulus time; a negedge monitor pops it on every f_valid.
module tb_fib_seq_gen;

   localparam int unsigned WIDTH    = 16;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned IDX_W    = 8;
   localparam longint      MAXV     = 65535;

   logic             clk = 1'b0;
   logic             rst, f_en, mode, clr;
   logic             f_valid, f_done;
   logic [WIDTH-1:0] f_out;
   logic [IDX_W-1:0] f_index;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   longint exp_val[$];
   longint exp_idx[$];
   longint m_a, m_b, m_idx;
   bit     m_done;

   fib_seq_gen #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .f_en(f_en), .mode(mode), .clr(clr),
      .f_valid(f_valid), .f_out(f_out), .f_index(f_index), .f_done(f_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_a = 0; m_b = 1; m_idx = 0; m_done = 0;
   endfunction

   // Unbounded arithmetic: a term is emitted only if it fits in WIDTH bits.
   function automatic void model_step();
      longint t;
      if (m_done) return;
      if (m_a > MAXV) begin
         m_done = 1;
         return;
      end
      m_idx++;
      exp_val.push_back(m_a);
      exp_idx.push_back(m_idx);
      t = m_a + m_b; m_a = m_b; m_b = t;
   endfunction

   always @(negedge clk) begin
      if (!rst && f_valid) begin
         n_pulses++;
         if (exp_val.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            chk("f_out", f_out, exp_val.pop_front());
            chk("f_index", f_index, exp_idx.pop_front());
         end
      end
   end

   task automatic step();
      f_en = 1'b1;
      model_step();
      @(negedge clk);
      f_en = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      int p0;
      rst = 1'b1; f_en = 1'b0; mode = 1'b0; clr = 1'b0;
      model_reset();
      #3;
      chk("rst_valid", f_valid, 0);
      chk("rst_out", f_out, 0);
      chk("rst_index", f_index, 0);
      chk("rst_done", f_done, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single-step: five pulses
      p0 = n_pulses;
      for (int i = 0; i < 5; i++) step();
      chk("ss_pulses", n_pulses - p0, 5);
      chk("ss_out", f_out, 3);
      chk("ss_index", f_index, 5);
      chk("ss_q_empty", exp_val.size(), 0);

      // level held high: one pulse only
      p0 = n_pulses;
      f_en = 1'b1;
      model_step();
      repeat (10) @(negedge clk);
      f_en = 1'b0;
      @(negedge clk); #1;
      chk("hold_pulses", n_pulses - p0, 1);
      chk("hold_q_empty", exp_val.size(), 0);

      // free-run: pulses every TICK_DIV edges, restart after f_en drop
      do_clr();
      mode = 1'b1; f_en = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         if (k % TICK_DIV == 0) model_step();
         @(negedge clk);
         chk("fr_valid", f_valid, (k % TICK_DIV == 0) ? 1 : 0);
      end
      f_en = 1'b0;
      repeat (2) @(negedge clk);
      f_en = 1'b1;
      for (int k = 1; k <= TICK_DIV; k++) begin
         if (k == TICK_DIV) model_step();
         @(negedge clk);
         chk("fr_restart_valid", f_valid, (k == TICK_DIV) ? 1 : 0);
      end
      f_en = 1'b0; mode = 1'b0;
      @(negedge clk); #1;
      chk("fr_index", f_index, 4);
      chk("fr_q_empty", exp_val.size(), 0);

      // clr coincident with a step
      do_clr();
      for (int i = 0; i < 7; i++) step();
      chk("pre_clr_index", f_index, 7);
      f_en = 1'b1; clr = 1'b1;
      @(negedge clk);
      f_en = 1'b0; clr = 1'b0;
      model_reset();
      chk("clr_valid", f_valid, 0);
      chk("clr_index", f_index, 0);
      chk("clr_out", f_out, 0);
      @(negedge clk);
      step();
      chk("post_clr_out", f_out, 0);
      chk("post_clr_index", f_index, 1);

      // overflow at WIDTH=16
      do_clr();
      for (int i = 0; i < 25; i++) step();
      chk("ovf_last_out", f_out, 46368);
      chk("ovf_last_index", f_index, 25);
      chk("ovf_not_done", f_done, 0);
      p0 = n_pulses;
      step();
      chk("ovf_done", f_done, m_done);
      chk("ovf_done_set", f_done, 1);
      step(); step();
      mode = 1'b1; f_en = 1'b1;
      repeat (3 * TICK_DIV) @(negedge clk);
      f_en = 1'b0; mode = 1'b0;
      @(negedge clk); #1;
      chk("done_no_pulse", n_pulses - p0, 0);
      chk("done_out_held", f_out, 46368);
      chk("done_index_held", f_index, 25);
      chk("done_still", f_done, 1);

      // async reset mid free-run
      do_clr();
      chk("clr_done_low", f_done, 0);
      mode = 1'b1; f_en = 1'b1;
      for (int k = 1; k <= 2 * TICK_DIV; k++) begin
         if (k % TICK_DIV == 0) model_step();
         @(negedge clk);
      end
      chk("pre_rst_valid", f_valid, 1);
      chk("pre_rst_done", f_done, 0);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", f_valid, 0);
      chk("arst_out", f_out, 0);
      chk("arst_index", f_index, 0);
      chk("arst_done", f_done, 0);
      mode = 1'b0; f_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      step();
      chk("post_rst_out", f_out, 0);
      chk("post_rst_index", f_index, 1);
      chk("final_q_empty", exp_val.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d checks expected completion", n_checks);
      $fatal(1, "timeout");
   end

endmodule
